// File: rtl/fu_control_sequencer.sv
// Fetch/decode/execute sequencer for the function-unit datapath.
// Fetches over req/ack, drives FS/SH/RF/MEM controls and latches flags.
module fu_control_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd1
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [4:0]  fu_fs,
  output logic [4:0]  fu_sh,
  input  logic        fu_z,
  input  logic        fu_n,
  input  logic        fu_v,
  input  logic        fu_c,
  output logic [4:0]  rf_da,
  output logic [4:0]  rf_aa,
  output logic [4:0]  rf_ba,
  output logic        rf_we,
  output logic        mb_sel,
  output logic        md_sel,
  output logic [31:0] imm,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic [3:0]  flags,
  output logic        halted
);

  localparam logic [6:0] OP_ADI  = 7'b0100010;
  localparam logic [6:0] OP_LD   = 7'b1000000;
  localparam logic [6:0] OP_ST   = 7'b1000001;
  localparam logic [6:0] OP_BZ   = 7'b1100000;
  localparam logic [6:0] OP_BN   = 7'b1100001;
  localparam logic [6:0] OP_JMP  = 7'b1100010;
  localparam logic [6:0] OP_HALT = 7'b1111111;

  typedef enum logic [1:0] {
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_HALT
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [31:0] pc;
  logic [31:0] ir;
  logic [3:0]  flg;
  logic [6:0]  op;

  logic is_alu;
  logic is_adi;
  logic is_ld;
  logic is_st;
  logic is_bz;
  logic is_bn;
  logic is_jmp;
  logic is_halt;
  logic taken;

  assign op      = ir[31:25];
  assign is_alu  = (op[6:5] == 2'b00);
  assign is_adi  = (op == OP_ADI);
  assign is_ld   = (op == OP_LD);
  assign is_st   = (op == OP_ST);
  assign is_bz   = (op == OP_BZ);
  assign is_bn   = (op == OP_BN);
  assign is_jmp  = (op == OP_JMP);
  assign is_halt = (op == OP_HALT);

  // pc already holds the incremented value while in EXEC
  assign taken = is_jmp
               | (is_bz & flg[3])
               | (is_bn & flg[2]);

  assign imem_addr = pc;
  assign rf_da     = ir[24:20];
  assign rf_aa     = ir[19:15];
  assign rf_ba     = ir[14:10];
  assign fu_sh     = ir[4:0];
  assign imm       = {{17{ir[14]}}, ir[14:0]};
  assign flags     = flg;
  assign halted    = (state == S_HALT);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= S_FETCH;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc  <= RESET_PC;
      ir  <= 32'h0;
      flg <= 4'h0;
    end else begin
      if (state == S_FETCH && imem_ack) begin
        ir <= imem_rdata;
        pc <= pc + PC_STEP;
      end
      if (state == S_EXEC) begin
        if (taken) pc <= pc + imm;
        if (is_alu || is_adi) flg <= {fu_z, fu_n, fu_v, fu_c};
      end
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_FETCH: if (imem_ack) state_nx = S_EXEC;
      S_EXEC: begin
        unique case (1'b1)
          is_ld, is_st: state_nx = S_MEM;
          is_halt:      state_nx = S_HALT;
          default:      state_nx = S_FETCH;
        endcase
      end
      S_MEM:   if (dmem_ack) state_nx = S_FETCH;
      default: state_nx = S_HALT;
    endcase
  end

  // requests and writes are masked while reset is held low
  always_comb begin
    imem_req = 1'b0;
    fu_fs    = 5'b00000;
    rf_we    = 1'b0;
    mb_sel   = 1'b0;
    md_sel   = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    unique case (state)
      S_FETCH: imem_req = reset_n;
      S_EXEC: begin
        unique case (1'b1)
          is_alu: begin
            fu_fs = op[4:0];
            rf_we = reset_n;
          end
          is_adi: begin
            fu_fs  = 5'b00010;
            mb_sel = 1'b1;
            rf_we  = reset_n;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        dmem_req = reset_n;
        dmem_we  = is_st;
        if (is_ld && dmem_ack) begin
          rf_we  = reset_n;
          md_sel = reset_n;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fu_control_sequencer.sv
// Testbench for fu_control_sequencer: directed table, corner
// sequences and random instruction streams against a reference model.
module tb_fu_control_sequencer;

  localparam logic [6:0] OP_ADI  = 7'b0100010;
  localparam logic [6:0] OP_LD   = 7'b1000000;
  localparam logic [6:0] OP_ST   = 7'b1000001;
  localparam logic [6:0] OP_BZ   = 7'b1100000;
  localparam logic [6:0] OP_BN   = 7'b1100001;
  localparam logic [6:0] OP_JMP  = 7'b1100010;
  localparam logic [6:0] OP_HALT = 7'b1111111;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [4:0]  fu_fs;
  logic [4:0]  fu_sh;
  logic        fu_z = 1'b0;
  logic        fu_n = 1'b0;
  logic        fu_v = 1'b0;
  logic        fu_c = 1'b0;
  logic [4:0]  rf_da;
  logic [4:0]  rf_aa;
  logic [4:0]  rf_ba;
  logic        rf_we;
  logic        mb_sel;
  logic        md_sel;
  logic [31:0] imm;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack = 1'b0;
  logic [3:0]  flags;
  logic        halted;

  fu_control_sequencer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .fu_fs      (fu_fs),
    .fu_sh      (fu_sh),
    .fu_z       (fu_z),
    .fu_n       (fu_n),
    .fu_v       (fu_v),
    .fu_c       (fu_c),
    .rf_da      (rf_da),
    .rf_aa      (rf_aa),
    .rf_ba      (rf_ba),
    .rf_we      (rf_we),
    .mb_sel     (mb_sel),
    .md_sel     (md_sel),
    .imm        (imm),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_ack   (dmem_ack),
    .flags      (flags),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  fs;
    logic        we;
    logic        mb;
    logic [31:0] npc;
    logic [3:0]  nfl;
  } exp_t;

  typedef struct {
    logic [31:0] ir;
    logic [3:0]  fz;
    int          iw;
    int          dw;
    exp_t        ex;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_addr = 32'h0;
  logic [3:0]  exp_flags = 4'h0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, want, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] op,
                                     input logic [4:0] dr,
                                     input logic [4:0] sa,
                                     input logic [14:0] lo);
    return {op, dr, sa, lo};
  endfunction

  // Instruction-level reference: what one instruction does to PC/flags
  function automatic exp_t model(input logic [31:0] ir,
                                 input logic [3:0] fz);
    exp_t        e;
    logic [6:0]  op;
    logic [31:0] pc1;
    logic [31:0] off;
    op  = ir[31:25];
    pc1 = exp_addr + 32'd1;
    off = {{17{ir[14]}}, ir[14:0]};
    e.fs  = 5'd0;
    e.we  = 1'b0;
    e.mb  = 1'b0;
    e.npc = pc1;
    e.nfl = exp_flags;
    if (op[6:5] == 2'b00) begin
      e.fs  = op[4:0];
      e.we  = 1'b1;
      e.nfl = fz;
    end else if (op == OP_ADI) begin
      e.fs  = 5'b00010;
      e.we  = 1'b1;
      e.mb  = 1'b1;
      e.nfl = fz;
    end else if (op == OP_JMP) begin
      e.npc = pc1 + off;
    end else if (op == OP_BZ && exp_flags[3]) begin
      e.npc = pc1 + off;
    end else if (op == OP_BN && exp_flags[2]) begin
      e.npc = pc1 + off;
    end
    return e;
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [6:0] op;
    int r;
    r = $urandom_range(0, 8);
    case (r)
      0, 1:    op = {2'b00, 5'($urandom)};
      2:       op = OP_ADI;
      3:       op = OP_LD;
      4:       op = OP_ST;
      5:       op = OP_BZ;
      6:       op = OP_BN;
      7:       op = OP_JMP;
      default: op = {3'b011, 4'($urandom)};
    endcase
    return {op, 25'($urandom)};
  endfunction

  task automatic run(input logic [31:0] ir, input logic [3:0] fz,
                     input int iw, input int dw, input exp_t ex,
                     input bit abort);
    logic [6:0] op;
    bit         ld;
    op = ir[31:25];
    ld = (op == OP_LD);
    for (int k = 0; k <= iw; k++) begin
      @(negedge clk);
      imem_ack   = (k == iw);
      imem_rdata = (k == iw) ? ir : $urandom;
      dmem_ack   = 1'($urandom);
      #1;
      chk("fetch_req", {31'h0, imem_req}, 32'h1);
      chk("fetch_addr", imem_addr, exp_addr);
      chk("fetch_flags", {28'h0, flags}, {28'h0, exp_flags});
      chk("fetch_we", {31'h0, rf_we | dmem_req}, 32'h0);
    end
    @(negedge clk);
    imem_ack   = 1'($urandom);
    imem_rdata = $urandom;
    dmem_ack   = 1'($urandom);
    {fu_z, fu_n, fu_v, fu_c} = fz;
    #1;
    chk("exec_fs", {27'h0, fu_fs}, {27'h0, ex.fs});
    chk("exec_we", {31'h0, rf_we}, {31'h0, ex.we});
    chk("exec_mb", {31'h0, mb_sel}, {31'h0, ex.mb});
    chk("exec_quiet", {29'h0, imem_req, dmem_req, md_sel}, 32'h0);
    chk("exec_regs", {17'h0, rf_da, rf_aa, rf_ba},
        {17'h0, ir[24:20], ir[19:15], ir[14:10]});
    chk("exec_imm", imm, {{17{ir[14]}}, ir[14:0]});
    chk("exec_sh", {27'h0, fu_sh}, {27'h0, ir[4:0]});
    if (op == OP_LD || op == OP_ST) begin
      for (int k = 0; k <= dw; k++) begin
        @(negedge clk);
        dmem_ack = (k == dw) && !abort;
        imem_ack = 1'($urandom);
        #1;
        chk("mem_req", {31'h0, dmem_req}, 32'h1);
        chk("mem_dwe", {31'h0, dmem_we}, {31'h0, op == OP_ST});
        chk("mem_rfwe", {31'h0, rf_we},
            {31'h0, ld && (k == dw) && !abort});
        chk("mem_mdsel", {31'h0, md_sel},
            {31'h0, ld && (k == dw) && !abort});
      end
      if (abort) return;
    end
    if (op == OP_HALT) begin
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        imem_ack = 1'($urandom);
        dmem_ack = 1'($urandom);
        #1;
        chk("halt_flag", {31'h0, halted}, 32'h1);
        chk("halt_quiet", {30'h0, imem_req, dmem_req}, 32'h0);
      end
    end
    exp_addr  = ex.npc;
    exp_flags = ex.nfl;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset_n  = 1'b0;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    #1;
    chk("rst_low_req", {29'h0, imem_req, rf_we, dmem_req}, 32'h0);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      chk("rst_req", {29'h0, imem_req, rf_we, dmem_req}, 32'h0);
      chk("rst_halted", {31'h0, halted}, 32'h0);
      chk("rst_flags", {28'h0, flags}, 32'h0);
      chk("rst_pc", imem_addr, 32'h0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    exp_addr  = 32'h0;
    exp_flags = 4'h0;
    @(posedge clk);
    #1;
    chk("post_rst_req", {31'h0, imem_req}, 32'h1);
  endtask

  vec_t tbl[14];

  initial begin
    tbl[0]  = '{mk(7'h02, 5'd3, 5'd1, {5'd2, 10'd0}), 4'b0000, 0, 0,
                '{5'h02, 1'b1, 1'b0, 32'd1, 4'b0000}};
    tbl[1]  = '{mk(7'h05, 5'd4, 5'd3, {5'd1, 10'd0}), 4'b1000, 0, 0,
                '{5'h05, 1'b1, 1'b0, 32'd2, 4'b1000}};
    tbl[2]  = '{mk(OP_BZ, 5'd0, 5'd0, 15'h7FFE), 4'b0110, 0, 0,
                '{5'h00, 1'b0, 1'b0, 32'd1, 4'b1000}};
    tbl[3]  = '{mk(7'h05, 5'd4, 5'd3, {5'd1, 10'd0}), 4'b0000, 5, 0,
                '{5'h05, 1'b1, 1'b0, 32'd2, 4'b0000}};
    tbl[4]  = '{mk(OP_BZ, 5'd0, 5'd0, 15'h7FFE), 4'b1111, 0, 0,
                '{5'h00, 1'b0, 1'b0, 32'd3, 4'b0000}};
    tbl[5]  = '{mk(OP_LD, 5'd7, 5'd2, 15'h0004), 4'b1111, 1, 3,
                '{5'h00, 1'b0, 1'b0, 32'd4, 4'b0000}};
    tbl[6]  = '{mk(OP_ADI, 5'd5, 5'd0, 15'd5), 4'b0100, 0, 0,
                '{5'h02, 1'b1, 1'b1, 32'd5, 4'b0100}};
    tbl[7]  = '{mk(OP_BN, 5'd0, 5'd0, 15'h0010), 4'b1011, 0, 0,
                '{5'h00, 1'b0, 1'b0, 32'd22, 4'b0100}};
    tbl[8]  = '{mk(OP_ST, 5'd0, 5'd6, 15'h0000), 4'b1111, 0, 1,
                '{5'h00, 1'b0, 1'b0, 32'd23, 4'b0100}};
    tbl[9]  = '{mk(OP_JMP, 5'd0, 5'd0, 15'h7FE8), 4'b1111, 2, 0,
                '{5'h00, 1'b0, 1'b0, 32'd0, 4'b0100}};
    tbl[10] = '{mk(7'b0111000, 5'd1, 5'd2, 15'h1234), 4'b1111, 0, 0,
                '{5'h00, 1'b0, 1'b0, 32'd1, 4'b0100}};
    tbl[11] = '{mk(7'h0D, 5'd9, 5'd8, {5'd2, 5'd0, 5'd7}), 4'b0011, 0, 0,
                '{5'h0D, 1'b1, 1'b0, 32'd2, 4'b0011}};
    tbl[12] = '{mk(OP_BN, 5'd0, 5'd0, 15'h0100), 4'b0100, 0, 0,
                '{5'h00, 1'b0, 1'b0, 32'd3, 4'b0011}};
    tbl[13] = '{mk(OP_HALT, 5'd0, 5'd0, 15'h0000), 4'b1111, 0, 0,
                '{5'h00, 1'b0, 1'b0, 32'd4, 4'b0011}};

    do_reset(2);

    for (int i = 0; i < 14; i++)
      run(tbl[i].ir, tbl[i].fz, tbl[i].iw, tbl[i].dw, tbl[i].ex, 1'b0);

    do_reset(1);

    for (int i = 0; i < 300; i++) begin
      logic [31:0] ir;
      logic [3:0]  fz;
      ir = rnd_instr();
      fz = 4'($urandom);
      run(ir, fz, $urandom_range(0, 3), $urandom_range(0, 3),
          model(ir, fz), 1'b0);
    end

    // store abandoned by reset while waiting on dmem_ack
    begin
      logic [31:0] ir;
      ir = mk(OP_ST, 5'd0, 5'd1, 15'h0040);
      run(ir, 4'b1111, 0, 1, model(ir, 4'b1111), 1'b1);
      do_reset(1);
      ir = mk(7'h02, 5'd2, 5'd2, 15'h0000);
      run(ir, 4'b1001, 0, 0, model(ir, 4'b1001), 1'b0);
      ir = mk(OP_HALT, 5'd0, 5'd0, 15'h0000);
      run(ir, 4'b0000, 1, 0, model(ir, 4'b0000), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
